// File: rtl/rng_game_pkg.sv
// Shared definitions for the game's random-draw path: draw FSM states,
// player indices and the default LFSR width.
package rng_game_pkg;

  // Draw sequencer states
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_STIR  = 2'd1,
    S_CHECK = 2'd2,
    S_RESP  = 2'd3
  } draw_state_t;

  // Player index into req/gnt vectors
  localparam int P1 = 0;
  localparam int P2 = 1;

  // Default LFSR width shared with the LFSR instance
  localparam int N_DEFAULT = 8;

endpackage

// File: rtl/rng_draw_arbiter_rr.sv
// rr_arbiter2: two-requester round-robin arbiter. The grant is purely
// combinational from req and the priority pointer; the pointer moves only
// when the owner strobes upd with the one-hot player it just served.
module rr_arbiter2
  import rng_game_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] req,
  input  logic       upd,
  input  logic [1:0] served,
  output logic [1:0] gnt
);

  // High when a tie should go to P2 (P1 was served last)
  logic prio_p2_q;

  // Priority pointer: after serving P1 favour P2, after serving P2 favour P1
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      prio_p2_q <= 1'b0;
    end else if (upd && (served != 2'b00)) begin
      prio_p2_q <= served[P1];
    end
  end

  // One-hot grant; single requester always wins, a tie follows the pointer
  always_comb begin
    gnt = 2'b00;
    if (req[P1] && req[P2]) begin
      if (prio_p2_q) gnt[P2] = 1'b1;
      else           gnt[P1] = 1'b1;
    end else begin
      gnt = req;
    end
  end

endmodule

// File: rtl/rng_draw_arbiter.sv
// rng_draw_arbiter: shares one maximal-length LFSR between two players.
// A granted draw steps the LFSR STIR times, samples it, and returns the value
// with a one-cycle valid/gnt pulse. All outputs come from registers or the
// state register, never combinationally from req.
// Build option: define RNG_RANGE_LIMIT_EN to reject samples above LIMIT; a
// rejected sample costs one extra LFSR step and a re-check.
module rng_draw_arbiter
  import rng_game_pkg::*;
#(
  parameter int N     = N_DEFAULT,
  parameter int STIR  = 5,
  parameter int LIMIT = 99
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [1:0]   req,
  input  logic [N-1:0] lfsr_q,
  output logic         lfsr_en,
  output logic         busy,
  output logic         valid,
  output logic [1:0]   gnt,
  output logic [N-1:0] data
);

`ifdef RNG_RANGE_LIMIT_EN
  localparam bit RANGE_EN = 1'b1;
`else
  localparam bit RANGE_EN = 1'b0;
`endif

  // Counter starts at STIR-1 so the STIR state lasts exactly STIR cycles
  localparam logic [7:0]   STIR_LOAD = 8'(STIR - 1);
  localparam logic [N-1:0] LIMIT_Q   = N'(LIMIT);

  draw_state_t  state_q, state_d;
  logic [7:0]   cnt_q;
  logic [1:0]   owner_q;
  logic [N-1:0] data_q;
  logic [1:0]   arb_gnt;
  logic         accept;

  // Without the range limit every sample is taken as-is
  assign accept = !RANGE_EN || (lfsr_q <= LIMIT_Q);

  rr_arbiter2 u_rr (
    .clk     (clk),
    .reset_n (reset_n),
    .req     (req),
    .upd     (state_q == S_RESP),
    .served  (owner_q),
    .gnt     (arb_gnt)
  );

  // State register
  always_ff @(posedge clk) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (req != 2'b00) state_d = S_STIR;
      S_STIR:  if (cnt_q == 8'd0) state_d = S_CHECK;
      S_CHECK: state_d = accept ? S_RESP : S_STIR;
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Step counter, latched owner and captured draw value
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt_q   <= 8'd0;
      owner_q <= 2'b00;
      data_q  <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req != 2'b00) begin
            cnt_q   <= STIR_LOAD;
            owner_q <= arb_gnt;
          end
        end
        S_STIR: begin
          if (cnt_q != 8'd0) cnt_q <= cnt_q - 8'd1;
        end
        S_CHECK: begin
          // A rejected sample leaves data untouched and buys one more step
          if (accept) data_q <= lfsr_q;
          else        cnt_q  <= 8'd0;
        end
        default: ;
      endcase
    end
  end

  // Moore outputs decoded from the state register
  always_comb begin
    lfsr_en = (state_q == S_STIR);
    busy    = (state_q != S_IDLE);
    valid   = (state_q == S_RESP);
    gnt     = (state_q == S_RESP) ? owner_q : 2'b00;
  end

  assign data = data_q;

endmodule

// File: tb/tb_rng_draw_arbiter.sv
// Bench for rng_draw_arbiter: an 8-bit LFSR (taps 8,6,5,4, seed 1) stepped
// by the DUT, directed scenarios followed by random request traffic, all
// checked against a draw-level reference model.
module tb_rng_draw_arbiter;

  localparam int N     = 8;
  localparam int STIR  = 5;
  localparam int LIMIT = 99;

`ifdef RNG_RANGE_LIMIT_EN
  localparam logic [N-1:0] FIRST_DATA = 8'h38;
  localparam int           FIRST_LAT  = 15;
`else
  localparam logic [N-1:0] FIRST_DATA = 8'h88;
  localparam int           FIRST_LAT  = 7;
`endif

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         lfsr_rst_n = 1'b0;
  logic [1:0]   req = 2'b00;
  logic [N-1:0] lfsr_q;
  logic         lfsr_en, busy, valid;
  logic [1:0]   gnt;
  logic [N-1:0] data;

  int errors = 0;
  int checks = 0;

  // Reference model state: LFSR value and whether P1 was served last
  logic [N-1:0] m_lfsr = 8'h01;
  logic         m_last_p1 = 1'b0;

  always #5 clk = ~clk;

  rng_draw_arbiter #(.N(N), .STIR(STIR), .LIMIT(LIMIT)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .req     (req),
    .lfsr_q  (lfsr_q),
    .lfsr_en (lfsr_en),
    .busy    (busy),
    .valid   (valid),
    .gnt     (gnt),
    .data    (data)
  );

  function automatic logic [N-1:0] lfsr_next(input logic [N-1:0] v);
    return {^(v & 8'h1D), v[N-1:1]};
  endfunction

  // Environment LFSR with its own reset
  always_ff @(posedge clk) begin
    if (!lfsr_rst_n)  lfsr_q <= 8'h01;
    else if (lfsr_en) lfsr_q <= lfsr_next(lfsr_q);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] model_gnt(input logic [1:0] r);
    if (r == 2'b11) return m_last_p1 ? 2'b10 : 2'b01;
    return r;
  endfunction

  // One draw: STIR steps, then (with the limit) one more per rejected value
  task automatic model_draw(output logic [N-1:0] d, output int retries);
    retries = 0;
    for (int i = 0; i < STIR; i++) m_lfsr = lfsr_next(m_lfsr);
`ifdef RNG_RANGE_LIMIT_EN
    while (m_lfsr > LIMIT[N-1:0]) begin
      m_lfsr = lfsr_next(m_lfsr);
      retries++;
    end
`endif
    d = m_lfsr;
  endtask

  task automatic apply_reset(input int cycles);
    reset_n = 1'b0;
    lfsr_rst_n = 1'b0;
    req = 2'b00;
    repeat (cycles) @(negedge clk);
    reset_n = 1'b1;
    lfsr_rst_n = 1'b1;
    m_lfsr = 8'h01;
    m_last_p1 = 1'b0;
  endtask

  // Called on a negedge while the DUT is idle with req already set; the next
  // rising edge starts the draw. Returns on the idle negedge after valid.
  task automatic run_draw(input logic [1:0] chg_req, input int chg_at,
                          output logic [1:0] got_gnt, output int got_lat);
    logic [1:0]   eg;
    logic [N-1:0] ed;
    int rt, cyc, en_cnt, first_en, busy_low;
    bit seen;
    eg = model_gnt(req);
    model_draw(ed, rt);
    cyc = 0; en_cnt = 0; first_en = 0; busy_low = 0; seen = 1'b0;
    while (!seen && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      if (cyc == chg_at) req = chg_req;
      if (lfsr_en === 1'b1) begin
        en_cnt++;
        if (first_en == 0) first_en = cyc;
      end
      if (busy !== 1'b1) busy_low++;
      if (valid === 1'b1) seen = 1'b1;
    end
    got_gnt = gnt;
    got_lat = cyc;
    check("valid_seen", 32'(seen), 32'd1);
    check("latency", cyc, STIR + 2 + 2 * rt);
    check("first_en_cycle", first_en, 1);
    check("lfsr_en_count", en_cnt, STIR + rt);
    check("busy_during_draw", busy_low, 0);
    check("gnt", 32'(gnt), 32'(eg));
    check("data", 32'(data), 32'(ed));
    m_last_p1 = eg[0];
    @(negedge clk);
    check("valid_width", 32'(valid), 32'd0);
    check("gnt_after", 32'(gnt), 32'd0);
    check("busy_after", 32'(busy), 32'd0);
    check("data_held", 32'(data), 32'(ed));
  endtask

  initial begin
    logic [1:0] g;
    int lat, vcount;

    // Reset state
    apply_reset(3);
    check("rst_lfsr_en", 32'(lfsr_en), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_gnt", 32'(gnt), 32'd0);
    check("rst_data", 32'(data), 32'd0);
    @(negedge clk);
    check("idle_no_req_busy", 32'(busy), 32'd0);

    // First P1 draw from seed 1
    req = 2'b01;
    run_draw(2'b01, 0, g, lat);
    check("first_gnt", 32'(g), 32'h1);
    check("first_lat", lat, FIRST_LAT);
    check("first_data", 32'(data), 32'(FIRST_DATA));
    req = 2'b00;

    // Tie from reset: P1, then P2, then P1
    apply_reset(2);
    req = 2'b11;
    run_draw(2'b11, 0, g, lat);
    check("tie_gnt1", 32'(g), 32'h1);
    run_draw(2'b11, 0, g, lat);
    check("tie_gnt2", 32'(g), 32'h2);
    run_draw(2'b11, 0, g, lat);
    check("tie_gnt3", 32'(g), 32'h1);
    req = 2'b00;
    @(negedge clk);

    // P1 drops req two cycles into STIR; draw still completes
    req = 2'b01;
    run_draw(2'b00, 2, g, lat);
    check("drop_gnt", 32'(g), 32'h1);

    // P2 raises during a P1 draw; served only after the P1 response
    req = 2'b01;
    run_draw(2'b10, 2, g, lat);
    check("raise_p1_gnt", 32'(g), 32'h1);
    run_draw(2'b00, 1, g, lat);
    check("raise_p2_gnt", 32'(g), 32'h2);
    check("raise_p2_spacing", lat + 1, STIR + 3);

    // P1 draw leaves the pointer favouring P2, then a draw aborted by reset
    req = 2'b01;
    run_draw(2'b01, 0, g, lat);
    repeat (3) @(negedge clk);
    check("abort_stir3_en", 32'(lfsr_en), 32'd1);
    reset_n = 1'b0;
    lfsr_rst_n = 1'b0;
    req = 2'b00;
    @(negedge clk);
    check("abort_lfsr_en", 32'(lfsr_en), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_valid", 32'(valid), 32'd0);
    check("abort_gnt", 32'(gnt), 32'd0);
    check("abort_data", 32'(data), 32'd0);
    reset_n = 1'b1;
    lfsr_rst_n = 1'b1;
    m_lfsr = 8'h01;
    m_last_p1 = 1'b0;
    vcount = 0;
    repeat (STIR + 3) begin
      @(negedge clk);
      if (valid !== 1'b0) vcount++;
    end
    check("abort_no_valid", vcount, 0);
    req = 2'b11;
    run_draw(2'b00, 1, g, lat);
    check("abort_ptr_reset_gnt", 32'(g), 32'h1);

    // Random request traffic
    for (int it = 0; it < 20; it++) begin
      int gap;
      gap = $urandom_range(0, 2);
      if (gap != 0) begin
        req = 2'b00;
        vcount = 0;
        repeat (gap) begin
          @(negedge clk);
          if (busy !== 1'b0) vcount++;
        end
        check("rand_idle_busy", vcount, 0);
      end
      req = 2'($urandom_range(1, 3));
      run_draw(2'($urandom_range(0, 3)), $urandom_range(1, STIR + 1), g, lat);
    end
    req = 2'b00;
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rng_draw_arbiter.md
# rng_draw_arbiter

Shares the game's single N-bit maximal-length LFSR between Player 1 and Player 2. Each player requests a random draw; the arbiter grants round-robin, steps the LFSR a fixed number of times to decorrelate consecutive draws, captures the value, and returns it with a one-cycle valid/grant pulse. It sits between the player input FSMs and the LFSR instance, and is the only driver of the LFSR enable.

## Interface
- N, 8, LFSR width; must match the LFSR instance
- STIR, 5, LFSR steps per draw; legal range 1..255
- LIMIT, 99, largest accepted draw when the range limit is compiled in; legal range 1..2^N-2
- clk  in  1  system clock, rising edge
- reset_n  in  1  reset, synchronous, active-low
- req  in  2  bit0 = P1, bit1 = P2; level request, held until own grant pulse
- lfsr_q  in  N  LFSR state, registered in the LFSR
- lfsr_en  out  1  LFSR step enable; Moore output of STIR state
- busy  out  1  high in every state except IDLE
- valid  out  1  one-cycle pulse; draw result available
- gnt  out  2  one-hot owner of the draw; nonzero only while valid=1
- data  out  N  drawn value; held until the next valid

## Operation
- States: IDLE, STIR, CHECK, RESP.
- IDLE: if req≠0, pick the owner via the round-robin pointer, load step counter = STIR-1, go to STIR. Otherwise stay.
- Round-robin: on a tie, the player not served last wins. The pointer resets to favour P1. The pointer updates only in RESP.
- STIR: lfsr_en=1. Counter decrements each cycle. Go to CHECK in the cycle the counter reaches 0, so exactly STIR enables are issued.
- CHECK: sample lfsr_q into data register; go to RESP (retry rule under Configuration).
- RESP: valid=1, gnt=owner one-hot, then go to IDLE.
- Owner dropping req mid-draw: the draw still completes and valid is issued.
- A req still high in the IDLE cycle after RESP starts a new draw.
- The other player's req is ignored until IDLE.
- Reset (reset_n=0 at an edge), including mid-draw:
  - state IDLE, lfsr_en=0, busy=0, valid=0, gnt=0, data=0, pointer favours P1.
  - The aborted draw produces no valid.
  - The LFSR has its own reset; this block does not reseed it.

## Timing
- A req sampled at IDLE edge t gives:
  - lfsr_en high in cycles t+1..t+STIR
  - CHECK at t+STIR+1
  - valid/gnt/data in cycle t+STIR+2
- Latency: STIR+2 cycles with no retries (7 at default).
- Each retry adds 2 cycles.
- Back-to-back draws: minimum spacing STIR+3 cycles (RESP→IDLE→STIR).
- Outputs are registered or decoded from the state register only; there is no combinational path from req.

## Configuration
- RNG_RANGE_LIMIT_EN defined:
  - In CHECK, if lfsr_q > LIMIT (unsigned), set counter=0 and return to STIR: one extra step, then re-check.
  - Retries are unbounded but terminate, because a maximal-length sequence contains values ≤ LIMIT.
  - Accepted data is always ≤ LIMIT.
- Undefined: CHECK always accepts; data spans 1..2^N-1 and LIMIT is unused.

## Structure
- Shared package `rng_game_pkg`:
  - state enum (IDLE, STIR, CHECK, RESP)
  - player index constants P1=0, P2=1
  - default N
- One sub-module, `rr_arbiter2`: 2-requester round-robin with a pointer-update strobe. It returns a one-hot grant; the arbiter registers that as the owner.

## Test plan
All scenarios use LFSR reset seed 1, taps 8,6,5,4, default parameters.
- Reset then hold req=01 → lfsr_en high 5 cycles; valid in cycle 7 after sampling, gnt=01.
  - Without macro: data=0x88.
  - With RNG_RANGE_LIMIT_EN: rejects 0x88, 0xC4, 0xE2, 0x71, then data=0x38 in cycle 15.
- req=11 from reset → first gnt=01. With req held, second gnt=10, third gnt=01. Each valid is exactly one cycle.
- P1 drops req two cycles into STIR → valid with gnt=01 still issued. busy falls the cycle after valid.
- reset_n low during STIR cycle 3 → next cycle all outputs 0 and state IDLE; no valid ever issued for that draw.
- P2 raises req during a P1 draw → P2 is not served until IDLE; P2 gnt=10 follows the P1 valid by STIR+3 cycles.
